// File: rtl/keypad_scanner.sv
// 4x3 matrix keypad scanner: walks an active-low row across the keypad, samples the
// synchronized columns once per row slot, and debounces press/release over whole scan frames.
module keypad_scanner #(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_FRAMES = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] col_n,
    output logic [3:0] row_n,
    output logic [3:0] keypad,
    output logic       key_strobe,
    output logic       busy
);

    localparam int SW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DF        = CW'(DEBOUNCE_FRAMES);

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        HELD
    } state_t;

    logic [2:0]    col_meta_q, col_sync_q;
    logic [SW-1:0] slot_q, slot_d;
    logic [1:0]    row_idx_q, row_idx_d;
    logic [3:0]    row_n_q, row_n_d;
    logic [1:0]    hits_q, hits_d;
    logic [3:0]    code_q, code_d;
    state_t        state_q, state_d;
    logic [3:0]    cand_q, cand_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] rel_q, rel_d;
    logic [3:0]    keypad_q, keypad_d;
    logic          strobe_q, strobe_d;

    logic          slot_last, frame_done;
    logic [2:0]    pressed;
    logic [1:0]    row_hits, hits_sum;
    logic [2:0]    hits_total;
    logic [3:0]    row_base, row_code, code_sum, frame_result;
    logic [CW-1:0] cnt_inc, rel_inc;

    // Columns are asynchronous to clk; nothing downstream sees col_n before two flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_meta_q <= 3'b111;
            col_sync_q <= 3'b111;
        end else begin
            // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
            col_meta_q <= col_n;
            col_sync_q <= col_meta_q;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        slot_last  = (slot_q == SLOT_LAST);
        frame_done = slot_last && (row_idx_q == 2'd3);
        slot_d     = slot_last ? '0 : slot_q + SW'(1);
        row_idx_d  = slot_last ? row_idx_q + 2'd1 : row_idx_q;
        row_n_d    = ~(4'b0001 << row_idx_d);

        pressed  = ~col_sync_q;
        row_hits = {1'b0, pressed[0]} + {1'b0, pressed[1]} + {1'b0, pressed[2]};
        row_base = ({2'b00, row_idx_q} << 1) + {2'b00, row_idx_q} + 4'd1;
        if (pressed[0])      row_code = row_base;
        else if (pressed[1]) row_code = row_base + 4'd1;
        else                 row_code = row_base + 4'd2;

        // Hit count saturates at 2: any multi-key frame reads as no key.
        hits_total   = {1'b0, hits_q} + {1'b0, row_hits};
        hits_sum     = (hits_total >= 3'd2) ? 2'd2 : hits_total[1:0];
        code_sum     = (row_hits == 2'd1) ? row_code : code_q;
        frame_result = (hits_sum == 2'd1) ? code_sum : 4'd0;

        hits_d = hits_q;
        code_d = code_q;
        if (frame_done) begin
            hits_d = 2'd0;
            code_d = 4'd0;
        end else if (slot_last) begin
            hits_d = hits_sum;
            code_d = code_sum;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_q    <= '0;
            row_idx_q <= 2'd0;
            row_n_q   <= 4'b1110;
            hits_q    <= 2'd0;
            code_q    <= 4'd0;
        end else begin
            slot_q    <= slot_d;
            row_idx_q <= row_idx_d;
            row_n_q   <= row_n_d;
            hits_q    <= hits_d;
            code_q    <= code_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        rel_d    = rel_q;
        keypad_d = keypad_q;
        strobe_d = 1'b0;
        cnt_inc  = cnt_q + CW'(1);
        rel_inc  = rel_q + CW'(1);

        if (frame_done) begin
            unique case (state_q)
                IDLE: begin
                    if (frame_result != 4'd0) begin
                        cand_d = frame_result;
                        if (DEBOUNCE_FRAMES == 1) begin
                            state_d  = HELD;
                            keypad_d = frame_result;
                            strobe_d = 1'b1;
                            cnt_d    = DF;
                            rel_d    = '0;
                        end else begin
                            state_d = DEBOUNCE;
                            cnt_d   = CW'(1);
                        end
                    end
                end
                DEBOUNCE: begin
                    if (frame_result == cand_q) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == DF) begin
                            state_d  = HELD;
                            keypad_d = cand_q;
                            strobe_d = 1'b1;
                            rel_d    = '0;
                        end
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        cand_d  = 4'd0;
                    end
                end
                HELD: begin
                    // Any result other than the held key, including a second key, counts toward release.
                    if (frame_result == cand_q) begin
                        rel_d = '0;
                    end else if (rel_inc == DF) begin
                        state_d  = IDLE;
                        keypad_d = 4'd0;
                        rel_d    = '0;
                        cnt_d    = '0;
                        cand_d   = 4'd0;
                    end else begin
                        rel_d = rel_inc;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cand_q   <= 4'd0;
            cnt_q    <= '0;
            rel_q    <= '0;
            keypad_q <= 4'd0;
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            rel_q    <= rel_d;
            keypad_q <= keypad_d;
            strobe_q <= strobe_d;
        end
    end

    assign row_n      = row_n_q;
    assign keypad     = keypad_q;
    assign key_strobe = strobe_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: a keypad matrix model drives col_n from row_n,
// and a scoreboard of expected keypad transitions is compared as the DUT updates keypad.
module tb_keypad_scanner;

    localparam int SCAN_DIV = 4;
    localparam int DF       = 3;
    localparam int FRAME    = 4 * SCAN_DIV;

    typedef struct packed {
        logic [3:0] code;
        logic       strobe;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] col_n;
    logic [3:0] row_n;
    logic [3:0] keypad;
    logic       key_strobe;
    logic       busy;
    logic [11:0] keys;

    exp_t exp_q[$];
    int   tests_run    = 0;
    int   tests_failed = 0;
    int   strobe_total = 0;

    always #5 clk = ~clk;

    // Pressed key at (r,c) shorts row r to column c.
    always_comb begin
        col_n = 3'b111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 3; c++)
                if (keys[3*r+c] && !row_n[r]) col_n[c] = 1'b0;
    end

    keypad_scanner #(
        .SCAN_DIV(SCAN_DIV),
        .DEBOUNCE_FRAMES(DF)
    ) dut (
        .clk(clk),
        .reset(reset),
        .col_n(col_n),
        .row_n(row_n),
        .keypad(keypad),
        .key_strobe(key_strobe),
        .busy(busy)
    );

    function automatic logic [11:0] key_bit(input int r, input int c);
        return 12'(1) << (3*r + c);
    endfunction

    task automatic push_exp(input logic [3:0] code, input logic strobe);
        exp_t e;
        e.code   = code;
        e.strobe = strobe;
        exp_q.push_back(e);
    endtask

    // Pops one expected entry for every keypad change seen outside reset.
    task automatic monitor();
        logic [3:0] prev_kp = 4'd0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_kp = keypad;
            end else if (keypad !== prev_kp) begin
                tests_run++;
                if (key_strobe === 1'b1) strobe_total++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL sb_unexpected_change: keypad %0d -> %0d strobe=%b, no change expected",
                             prev_kp, keypad, key_strobe);
                end else begin
                    e = exp_q.pop_front();
                    if (keypad !== e.code || key_strobe !== e.strobe) begin
                        tests_failed++;
                        $display("FAIL sb_transition: got keypad=%0d strobe=%b, expected keypad=%0d strobe=%b",
                                 keypad, key_strobe, e.code, e.strobe);
                    end
                end
                prev_kp = keypad;
            end else if (key_strobe !== 1'b0) begin
                tests_run++;
                tests_failed++;
                strobe_total++;
                $display("FAIL sb_stray_strobe: key_strobe=%b with keypad steady at %0d, expected 0",
                         key_strobe, keypad);
            end
        end
    endtask

    task automatic wait_scoreboard(input string name, input int limit);
        int n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL %s: %0d expected transition(s) still pending after %0d cycles, expected 0",
                     name, exp_q.size(), limit);
        end
    endtask

    task automatic do_reset(input logic [11:0] k);
        @(posedge clk);
        #1;
        reset = 1'b1;
        keys  = '0;
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL leftover_expectations: %0d pending, expected 0", exp_q.size());
        end
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        keys = k;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic check_val(input string name, input logic [3:0] got, input logic [3:0] want);
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("FAIL %s: got %0d (%b), expected %0d (%b)", name, got, got, want, want);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        tests_run++;
        if (row_n !== 4'b1110 || keypad !== 4'd0 || key_strobe !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_values: row_n=%b keypad=%0d strobe=%b busy=%b, expected 1110 0 0 0",
                     row_n, keypad, key_strobe, busy);
        end
    endtask

    task automatic test_hold_steady();
        int s0;
        int bad_row = 0;
        int bad_kp = 0;
        logic [3:0] row_exp;
        logic [3:0] row_got;
        logic [3:0] row_want;
        s0 = strobe_total;
        do_reset(key_bit(1, 1));
        push_exp(4'd5, 1'b1);
        for (int k = 0; k < 2 * FRAME; k++) begin
            @(negedge clk);
            row_exp = ~(4'b0001 << ((k / SCAN_DIV) % 4));
            if (row_n !== row_exp && bad_row == 0) begin
                bad_row  = 1;
                row_got  = row_n;
                row_want = row_exp;
            end
        end
        tests_run++;
        if (bad_row != 0) begin
            tests_failed++;
            $display("FAIL row_scan: row_n=%b, expected %b", row_got, row_want);
        end
        wait_scoreboard("hold5_accept", 4 * FRAME + 3 - 2 * FRAME);
        check_val("hold5_keypad", keypad, 4'd5);
        for (int k = 0; k < 3 * FRAME; k++) begin
            @(negedge clk);
            if (keypad !== 4'd5) bad_kp++;
        end
        tests_run++;
        if (bad_kp != 0) begin
            tests_failed++;
            $display("FAIL hold5_stable: keypad left 5 in %0d cycles, expected 0", bad_kp);
        end
        check_val("hold5_strobes", 4'(strobe_total - s0), 4'd1);
    endtask

    task automatic test_bounce();
        int s0;
        s0 = strobe_total;
        do_reset('0);
        for (int i = 0; i < 8; i++) begin
            keys = (i % 2 == 0) ? key_bit(3, 2) : 12'd0;
            repeat (5) @(posedge clk);
            #1;
        end
        check_val("bounce_no_strobe", 4'(strobe_total - s0), 4'd0);
        check_val("bounce_keypad_idle", keypad, 4'd0);
        keys = key_bit(3, 2);
        push_exp(4'd12, 1'b1);
        wait_scoreboard("bounce_accept", 6 * FRAME);
        repeat (2 * FRAME) @(negedge clk);
        check_val("bounce_strobes", 4'(strobe_total - s0), 4'd1);
        check_val("bounce_keypad", keypad, 4'd12);
    endtask

    task automatic test_release();
        int s0;
        int bad_kp = 0;
        do_reset(key_bit(3, 0));
        push_exp(4'd10, 1'b1);
        wait_scoreboard("star_accept", 4 * FRAME + 3);
        s0 = strobe_total;
        keys = '0;
        push_exp(4'd0, 1'b0);
        for (int k = 0; k < 2 * FRAME; k++) begin
            @(negedge clk);
            if (keypad !== 4'd10) bad_kp++;
        end
        tests_run++;
        if (bad_kp != 0) begin
            tests_failed++;
            $display("FAIL star_release_hold: keypad left 10 in %0d of %0d cycles, expected 0",
                     bad_kp, 2 * FRAME);
        end
        wait_scoreboard("star_release", FRAME + 8);
        check_val("star_release_no_strobe", 4'(strobe_total - s0), 4'd0);
    endtask

    task automatic test_multi_key();
        int s0;
        int bad_kp = 0;
        int bad_busy = 0;
        s0 = strobe_total;
        do_reset(key_bit(0, 0) | key_bit(0, 2));
        for (int k = 0; k < 6 * FRAME; k++) begin
            @(negedge clk);
            if (keypad !== 4'd0) bad_kp++;
            if (busy !== 1'b0) bad_busy++;
        end
        tests_run++;
        if (bad_kp != 0 || bad_busy != 0) begin
            tests_failed++;
            $display("FAIL multi_key: keypad nonzero %0d cycles, busy high %0d cycles, expected 0 and 0",
                     bad_kp, bad_busy);
        end
        check_val("multi_key_strobes", 4'(strobe_total - s0), 4'd0);
    endtask

    task automatic test_back_to_back();
        int s0;
        do_reset(key_bit(3, 1));
        push_exp(4'd11, 1'b1);
        wait_scoreboard("zero_accept", 4 * FRAME + 3);
        s0 = strobe_total;
        keys = key_bit(3, 1) | key_bit(2, 1);
        push_exp(4'd0, 1'b0);
        push_exp(4'd8, 1'b1);
        repeat (FRAME) @(negedge clk);
        check_val("second_key_ignored", keypad, 4'd11);
        keys = key_bit(2, 1);
        wait_scoreboard("eight_accept", 10 * FRAME);
        check_val("eight_keypad", keypad, 4'd8);
        check_val("eight_strobes", 4'(strobe_total - s0), 4'd1);
    endtask

    task automatic test_reset_mid();
        int n = 0;
        int first_n = -1;
        int early = 0;
        do_reset(key_bit(0, 1));
        while (busy !== 1'b1 && n < 2 * FRAME) begin
            @(negedge clk);
            n++;
        end
        repeat (FRAME) @(negedge clk);
        n = 0;
        while (row_n === 4'b1110 && n < 8) begin
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (busy !== 1'b1 || row_n === 4'b1110) begin
            tests_failed++;
            $display("FAIL mid_debounce_state: busy=%b row_n=%b, expected busy 1 and row_n not 1110",
                     busy, row_n);
        end
        #1;
        reset = 1'b1;
        #1;
        tests_run++;
        if (row_n !== 4'b1110 || keypad !== 4'd0 || key_strobe !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_reset_async: row_n=%b keypad=%0d strobe=%b busy=%b, expected 1110 0 0 0",
                     row_n, keypad, key_strobe, busy);
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        push_exp(4'd2, 1'b1);
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (k <= 45 && keypad !== 4'd0) early++;
            if (first_n < 0 && keypad === 4'd2) first_n = k;
        end
        tests_run++;
        if (early != 0 || first_n < 46 || first_n > 52) begin
            tests_failed++;
            $display("FAIL mid_reset_redebounce: early=%0d first accept cycle %0d, expected 0 and 46..52",
                     early, first_n);
        end
        wait_scoreboard("two_accept", 4);
    endtask

    initial begin
        reset = 1'b1;
        keys  = '0;
        fork
            monitor();
        join_none
        test_reset();
        test_hold_steady();
        test_bounce();
        test_release();
        test_multi_key();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
Scans a 4x3 matrix keypad (keys 1-9, *, 0, #) and produces the debounced 4-bit key code consumed by the vending control FSM's keypad input. Drives rows one at a time and samples the columns. Debounces press and release over whole scan frames. Presents a nonzero code for as long as one key is held, and 4'b0000 when no key is pressed.

Parameters:
SCAN_DIV, 1000, clock cycles each row is driven low; must be >= 2.
DEBOUNCE_FRAMES, 8, consecutive identical scan frames required to accept a press or a release; must be >= 1.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
col_n  input  3  column sense lines, active low, externally pulled up, asynchronous to clk
row_n  output  4  row drive lines, active low, exactly one bit low at any time
keypad  output  4  debounced key code; 4'b0000 = no key
key_strobe  output  1  one-cycle pulse when a new press is accepted
busy  output  1  high while in DEBOUNCE or HELD

Behaviour:
- Reset (async, active-high):
  - row_n=4'b1110, keypad=0, key_strobe=0, busy=0.
  - State IDLE; all counters, candidate and frame accumulator cleared.
- Input sync: col_n passes through a 2-flop synchronizer before any use.
- Row scan:
  - Slot counter counts 0..SCAN_DIV-1 per row, then the row index advances 0->1->2->3->0.
  - row_n = ~(1<<row_idx), registered.
  - Synchronized columns are sampled only in the last cycle of each slot, which gives the lines time to settle.
- Frame evaluation:
  - A frame is 4*SCAN_DIV cycles and ends at the last cycle of the row-3 slot, where frame_done pulses.
  - Frame result = code of the single pressed key.
  - Frame result = 0 if no key is pressed, or if more than one key is detected in the frame (multi-key is always treated as no key).
- Code map (row r, col c): code = 3*r + c + 1.
  - '1'..'9' -> 1..9, '*' -> 10, '0' -> 11, '#' -> 12.
  - Codes 13-15 are never produced.
- FSM (updates only on frame_done):
  - IDLE: result != 0 -> DEBOUNCE, cand=result, cnt=1. If DEBOUNCE_FRAMES==1, go directly to HELD with the press actions below.
  - DEBOUNCE, result == cand: cnt++. When cnt reaches DEBOUNCE_FRAMES -> HELD; keypad<=cand; key_strobe=1 for exactly one cycle.
  - DEBOUNCE, result != cand: -> IDLE, cnt=0, no output change. A different nonzero key does not restart debounce until the next frame.
  - HELD, result == cand: rel_cnt=0, keypad held.
  - HELD, result != cand (0 or another key): rel_cnt++. When rel_cnt reaches DEBOUNCE_FRAMES -> IDLE; keypad<=0; no strobe.
  - A second key pressed while HELD is ignored until the release is accepted.
- Latency: keypad and key_strobe update in the cycle after the accepting frame_done edge.
- Output stability: keypad changes only at press acceptance or release acceptance; it never glitches between codes.
- busy = (state != IDLE).
- Reset mid-operation returns to the reset state immediately. No strobe is emitted, and a held key must be re-debounced from IDLE.
- Counter widths are $clog2-sized. Counters never wrap past their terminal values.

Test Plan:
SCAN_DIV=4 and DEBOUNCE_FRAMES=3 are used throughout (frame = 16 cycles).
1. Hold '5' (row1, col1) steady from cycle 0 -> keypad=5 and key_strobe high for exactly 1 cycle, within 4 frames + 3 cycles; keypad stays 5 while held; row_n cycles 1110, 1101, 1011, 0111 every 4 cycles.
2. Bounce '#' (row3, col2) on/off every 5 cycles for 40 cycles, then hold steady -> no strobe during bounce; exactly one strobe afterwards; keypad=12.
3. Hold '*' until accepted, then release -> keypad stays 10 for 2 further frames; keypad=0 after the 3rd clean frame; no strobe on release.
4. Press '1' and '3' together (row0, col0 and col2) -> keypad stays 0, no strobe, busy stays 0.
5. Hold '0' until accepted, then add '8' while '0' remains held, then release '0' with '8' still held -> keypad=11, then 0 after the release debounce, then 8 with a new strobe 3 frames later.
6. Assert reset 2 frames into debouncing '2' -> outputs return to reset values in the same cycle; after deassert with the key still held, keypad=2 only after 3 full new frames.
